// File: rtl/sar_conv_seq.sv
// SAR conversion sequencer: sample phase, then one compare/decide pair per bit.
// Every output is a flop; cmp_en especially, since it gates the comparator clock.
module sar_conv_seq #(
  parameter int N_BITS        = 10,
  parameter int SAMPLE_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      comp_out,
  output logic                      busy,
  output logic                      sample,
  output logic                      cmp_en,
  output logic [N_BITS-1:0]         dac_code,
  output logic [$clog2(N_BITS)-1:0] bit_idx,
  output logic [N_BITS-1:0]         result,
  output logic                      valid
);

  localparam int IW = $clog2(N_BITS);
  localparam int CW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, SAMPLE, CMP, DEC, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [N_BITS-1:0] decided;
  logic [N_BITS-1:0] trial;

  // decided: current bit resolved by the comparator; trial: next lower bit set for testing
  always_comb begin
    decided          = dac_code;
    decided[bit_idx] = comp_out;
    trial            = decided;
    if (bit_idx != '0) trial[bit_idx - IW'(1)] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      sample   <= 1'b0;
      cmp_en   <= 1'b0;
      dac_code <= '0;
      bit_idx  <= '0;
      result   <= '0;
      valid    <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (abort) begin
        state    <= IDLE;
        busy     <= 1'b0;
        sample   <= 1'b0;
        cmp_en   <= 1'b0;
        dac_code <= '0;
        bit_idx  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state  <= SAMPLE;
              busy   <= 1'b1;
              sample <= 1'b1;
              cnt    <= CW'(SAMPLE_CYCLES - 1);
            end
          end
          SAMPLE: begin
            if (cnt == '0) begin
              state    <= CMP;
              sample   <= 1'b0;
              cmp_en   <= 1'b1;
              bit_idx  <= IW'(N_BITS - 1);
              dac_code <= {1'b1, {(N_BITS-1){1'b0}}};
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          CMP: begin
            state  <= DEC;
            cmp_en <= 1'b0;
          end
          DEC: begin
            // Result is loaded on the same edge that raises valid
            if (bit_idx == '0) begin
              state    <= DONE;
              dac_code <= decided;
              result   <= decided;
              valid    <= 1'b1;
            end else begin
              state    <= CMP;
              cmp_en   <= 1'b1;
              dac_code <= trial;
              bit_idx  <= bit_idx - IW'(1);
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sar_conv_seq.sv
// Self-checking bench for sar_conv_seq: a 4-bit/2-sample instance for most scenarios
// and a default-parameter instance; ideal comparator, expected codes from SAR arithmetic.
module tb_sar_conv_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start4, abort4, comp4;
  logic [3:0] vin4;
  logic       busy4, sample4, cmp4, valid4;
  logic [3:0] dac4, result4;
  logic [1:0] idx4;

  logic       start10, abort10, comp10;
  logic [9:0] vin10;
  logic       busy10, sample10, cmp10, valid10;
  logic [9:0] dac10, result10;
  logic [3:0] idx10;

  // Ideal comparator: high when the input is at or above the trial code
  assign comp4  = (vin4 >= dac4);
  assign comp10 = (vin10 >= dac10);

  sar_conv_seq #(.N_BITS(4), .SAMPLE_CYCLES(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4), .comp_out(comp4),
    .busy(busy4), .sample(sample4), .cmp_en(cmp4), .dac_code(dac4),
    .bit_idx(idx4), .result(result4), .valid(valid4)
  );

  sar_conv_seq dut10 (
    .clk(clk), .rst_n(rst_n), .start(start10), .abort(abort10), .comp_out(comp10),
    .busy(busy10), .sample(sample10), .cmp_en(cmp10), .dac_code(dac10),
    .bit_idx(idx10), .result(result10), .valid(valid10)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int         obs_lat, obs_pulses, obs_wide, obs_samples, obs_valids, obs_busy_after;
  logic [3:0] obs_trials [4];
  logic [3:0] obs_result;
  logic [2:0] obs_ab_flags;
  logic [3:0] obs_ab_dac;

  // Successive approximation for bit b keeps the higher bits of vin and sets bit b
  function automatic logic [3:0] exp_trial(input logic [3:0] v, input int b);
    logic [3:0] hi;
    hi = (v >> (b + 1)) << (b + 1);
    return hi | (4'd1 << b);
  endfunction

  // One conversion on the 4-bit instance, recording what was observed each cycle
  task automatic convert4(input logic [3:0] v, input logic [63:0] pulse,
                          input int abort_cycle, input int extra);
    logic prev_cmp;
    obs_lat = 0; obs_pulses = 0; obs_wide = 0; obs_samples = 0;
    obs_valids = 0; obs_busy_after = 0; prev_cmp = 1'b0;
    obs_ab_flags = 3'b111; obs_ab_dac = 4'hf;
    vin4 = v;
    @(negedge clk);
    start4 = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start4 = pulse[c];
      abort4 = (abort_cycle != 0) && (c == abort_cycle);
      if (abort_cycle != 0 && c == abort_cycle + 1) begin
        obs_ab_flags = {busy4, sample4, cmp4};
        obs_ab_dac   = dac4;
      end
      if (sample4) obs_samples++;
      if (cmp4) begin
        if (obs_pulses < 4) obs_trials[obs_pulses] = dac4;
        obs_pulses++;
        if (prev_cmp) obs_wide++;
      end
      prev_cmp = cmp4;
      if (obs_lat != 0 && busy4) obs_busy_after++;
      if (valid4) begin
        obs_valids++;
        if (obs_lat == 0) begin
          obs_lat    = c;
          obs_result = result4;
        end
      end
      if (obs_lat != 0 && c >= obs_lat + extra) break;
    end
    start4 = 1'b0;
    abort4 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start4 = 0; abort4 = 0; vin4 = 0;
    start10 = 0; abort10 = 0; vin10 = 0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy4, sample4, cmp4, valid4, dac4, idx4, result4} !== 14'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_state4: got %h expected 0", {busy4, sample4, cmp4, valid4, dac4, idx4, result4});
    end
    n_checks++;
    if ({busy10, sample10, cmp10, valid10, dac10, idx10, result10} !== 28'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_state10: got %h expected 0", {busy10, sample10, cmp10, valid10, dac10, idx10, result10});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    convert4(4'b1011, 64'd0, 0, 1);
    n_checks++;
    if (obs_lat !== 11) begin n_fail++; $display("[TB] FAIL basic_latency: got %0d expected 11", obs_lat); end
    n_checks++;
    if (obs_result !== 4'b1011) begin n_fail++; $display("[TB] FAIL basic_result: got %b expected 1011", obs_result); end
    n_checks++;
    if (obs_pulses !== 4 || obs_wide !== 0) begin
      n_fail++; $display("[TB] FAIL basic_cmp_pulses: got %0d pulses %0d wide expected 4 pulses 0 wide", obs_pulses, obs_wide);
    end
    n_checks++;
    if (obs_samples !== 2) begin n_fail++; $display("[TB] FAIL basic_sample_len: got %0d expected 2", obs_samples); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (obs_trials[i] !== exp_trial(4'b1011, 3 - i)) begin
        n_fail++; $display("[TB] FAIL basic_trial%0d: got %b expected %b", i, obs_trials[i], exp_trial(4'b1011, 3 - i));
      end
    end
    n_checks++;
    if (obs_valids !== 1 || obs_busy_after !== 0) begin
      n_fail++; $display("[TB] FAIL basic_valid_busy: got valids %0d busy_after %0d expected 1 and 0", obs_valids, obs_busy_after);
    end
  endtask

  task automatic test_extremes();
    logic [3:0] v;
    for (int k = 0; k < 2; k++) begin
      v = (k == 0) ? 4'd0 : 4'd15;
      convert4(v, 64'd0, 0, 1);
      n_checks++;
      if (obs_result !== v) begin n_fail++; $display("[TB] FAIL extreme_result: got %b expected %b", obs_result, v); end
      n_checks++;
      if (obs_valids !== 1 || obs_busy_after !== 0) begin
        n_fail++; $display("[TB] FAIL extreme_valid_busy: got valids %0d busy_after %0d expected 1 and 0", obs_valids, obs_busy_after);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] v;
    for (int k = 0; k < 6; k++) begin
      v = 4'($urandom_range(0, 15));
      convert4(v, 64'd0, 0, 1);
      n_checks++;
      if (obs_result !== v || obs_lat !== 11) begin
        n_fail++; $display("[TB] FAIL random_conv: got %b at %0d expected %b at 11", obs_result, obs_lat, v);
      end
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (obs_trials[i] !== exp_trial(v, 3 - i)) begin
          n_fail++; $display("[TB] FAIL random_trial%0d: got %b expected %b", i, obs_trials[i], exp_trial(v, 3 - i));
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [63:0] pulse;
    logic [3:0]  v;
    pulse = '0;
    pulse[1] = 1'b1; pulse[3] = 1'b1; pulse[11] = 1'b1;
    v = 4'($urandom_range(0, 15));
    convert4(v, pulse, 0, 8);
    n_checks++;
    if (obs_lat !== 11 || obs_result !== v) begin
      n_fail++; $display("[TB] FAIL start_ignored_conv: got %b at %0d expected %b at 11", obs_result, obs_lat, v);
    end
    n_checks++;
    if (obs_valids !== 1 || obs_busy_after !== 0) begin
      n_fail++; $display("[TB] FAIL start_ignored_extra: got valids %0d busy_after %0d expected 1 and 0", obs_valids, obs_busy_after);
    end
  endtask

  task automatic test_back_to_back();
    int vt [$];
    int idle_cycles;
    int bad_res;
    idle_cycles = 0; bad_res = 0;
    vin4 = 4'b0110;
    @(negedge clk);
    start4 = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (!busy4) idle_cycles++;
      if (valid4) begin
        vt.push_back(c);
        if (result4 !== 4'b0110) bad_res++;
      end
    end
    start4 = 1'b0;
    n_checks++;
    if (vt.size() !== 3 || vt[0] !== 11 || vt[1] !== 23 || vt[2] !== 35) begin
      n_fail++; $display("[TB] FAIL b2b_valid_times: got %p expected 11 23 35", vt);
    end
    n_checks++;
    if (idle_cycles !== 3 || bad_res !== 0) begin
      n_fail++; $display("[TB] FAIL b2b_idle_result: got idle %0d bad %0d expected 3 and 0", idle_cycles, bad_res);
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!busy4) break;
    end
    n_checks++;
    if (busy4 !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_drain: got busy %b expected 0", busy4); end
  endtask

  task automatic test_abort();
    convert4(4'b0101, 64'd0, 0, 1);
    convert4(4'b1110, 64'd0, 8, 0);
    n_checks++;
    if (obs_ab_flags !== 3'b000 || obs_ab_dac !== 4'd0) begin
      n_fail++; $display("[TB] FAIL abort_outputs: got flags %b dac %b expected 000 0000", obs_ab_flags, obs_ab_dac);
    end
    n_checks++;
    if (obs_valids !== 0 || obs_pulses !== 3) begin
      n_fail++; $display("[TB] FAIL abort_valids: got valids %0d pulses %0d expected 0 and 3", obs_valids, obs_pulses);
    end
    n_checks++;
    if (result4 !== 4'b0101 || busy4 !== 1'b0) begin
      n_fail++; $display("[TB] FAIL abort_result: got %b busy %b expected 0101 busy 0", result4, busy4);
    end
  endtask

  task automatic test_async_reset();
    vin4 = 4'd9;
    @(negedge clk);
    start4 = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      start4 = 1'b0;
    end
    n_checks++;
    if (cmp4 !== 1'b1) begin n_fail++; $display("[TB] FAIL areset_in_cmp: got cmp_en %b expected 1", cmp4); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy4, sample4, cmp4, valid4, dac4, idx4, result4} !== 14'd0) begin
      n_fail++; $display("[TB] FAIL areset_outputs: got %h expected 0", {busy4, sample4, cmp4, valid4, dac4, idx4, result4});
    end
    @(negedge clk);
    rst_n = 1'b1;
    convert4(4'd9, 64'd0, 0, 1);
    n_checks++;
    if (obs_result !== 4'd9 || obs_lat !== 11) begin
      n_fail++; $display("[TB] FAIL areset_reconvert: got %b at %0d expected 1001 at 11", obs_result, obs_lat);
    end
  endtask

  task automatic test_defaults();
    logic [9:0] v;
    int lat, samples, pulses;
    logic [9:0] res;
    for (int k = 0; k < 2; k++) begin
      v = (k == 0) ? 10'h2A5 : 10'($urandom_range(0, 1023));
      vin10 = v; lat = 0; samples = 0; pulses = 0; res = '0;
      @(negedge clk);
      start10 = 1'b1;
      for (int c = 1; c <= 80; c++) begin
        @(negedge clk);
        start10 = 1'b0;
        if (sample10) samples++;
        if (cmp10) pulses++;
        if (valid10 && lat == 0) begin
          lat = c;
          res = result10;
        end
        if (lat != 0 && c >= lat + 1) break;
      end
      n_checks++;
      if (res !== v || lat !== 25) begin
        n_fail++; $display("[TB] FAIL defaults_conv: got %h at %0d expected %h at 25", res, lat, v);
      end
      n_checks++;
      if (samples !== 4 || pulses !== 10) begin
        n_fail++; $display("[TB] FAIL defaults_phases: got sample %0d pulses %0d expected 4 and 10", samples, pulses);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_defaults();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
